// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Raster timing generator for 640x480@60 Hz from a 50 MHz
//                clock. A clock divider produces the pixel enable and the
//                DAC pixel clock. Registered pixel/line counters drive the
//                sync, active-video, frame tick and animation toggle outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int CLK_DIV      = 2,
  parameter int TROCA_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] h_counter,
  output logic [9:0] v_counter,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk,
  output logic       pix_en,
  output logic       frame_tick,
  output logic       troca
);

  // --------------------------------------------------------------------------
  // Derived geometry
  // --------------------------------------------------------------------------
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FC_W  = (TROCA_FRAMES > 1) ? $clog2(TROCA_FRAMES) : 1;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END    = 10'(H_VISIBLE);
  localparam logic [9:0] V_ACT_END    = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(TROCA_FRAMES - 1);

  // --------------------------------------------------------------------------
  // Parameter sanity: reject configurations the counters cannot represent
  // --------------------------------------------------------------------------
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end
  if (TROCA_FRAMES < 1) begin : g_bad_troca
    $error("vga_timing_gen: TROCA_FRAMES must be at least 1");
  end
  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_geometry
    $error("vga_timing_gen: line or frame total exceeds 10-bit counter range");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q,        div_d;
  logic             pix_en_q,     pix_en_d;
  logic             vga_clk_q,    vga_clk_d;
  logic [9:0]       h_q,          h_d;
  logic [9:0]       v_q,          v_d;
  logic             hsync_q,      hsync_d;
  logic             vsync_q,      vsync_d;
  logic             active_q,     active_d;
  logic             frame_tick_q, frame_tick_d;
  logic [FC_W-1:0]  fc_q,         fc_d;
  logic             troca_q,      troca_d;

  logic h_wrap;
  logic v_wrap;
  logic frame_wrap;

  // Pixel divider; pix_en and vga_clk are registered from the next divider
  // value so they always match div_q without a combinational output path.
  always_comb begin
    div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_en_d  = (div_d == DIV_LAST);
    vga_clk_d = (div_d >= DIV_HALF);
  end

  // Raster counters advance once per pixel; line wrap steps the line counter.
  always_comb begin
    h_wrap     = (h_q == H_LAST);
    v_wrap     = (v_q == V_LAST);
    frame_wrap = pix_en_q && h_wrap && v_wrap;
    h_d        = h_q;
    v_d        = v_q;
    if (pix_en_q) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Sync/active decode from the next counter values, loaded only on pixel
  // edges so the held reset values stay put until the first pixel arrives.
  always_comb begin
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    active_d = active_q;
    if (pix_en_q) begin
      hsync_d  = !((h_d >= H_SYNC_START) && (h_d < H_SYNC_END));
      vsync_d  = !((v_d >= V_SYNC_START) && (v_d < V_SYNC_END));
      active_d = (h_d < H_ACT_END) && (v_d < V_ACT_END);
    end
  end

  // Frame tick and animation phase: troca flips every TROCA_FRAMES wraps.
  always_comb begin
    frame_tick_d = frame_wrap;
    fc_d         = fc_q;
    troca_d      = troca_q;
    if (frame_wrap) begin
      if (fc_q == FC_LAST) begin
        fc_d    = '0;
        troca_d = ~troca_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous reset to the idle raster origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      pix_en_q     <= 1'b0;
      vga_clk_q    <= 1'b0;
      h_q          <= '0;
      v_q          <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      active_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      fc_q         <= '0;
      troca_q      <= 1'b0;
    end else begin
      div_q        <= div_d;
      pix_en_q     <= pix_en_d;
      vga_clk_q    <= vga_clk_d;
      h_q          <= h_d;
      v_q          <= v_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      active_q     <= active_d;
      frame_tick_q <= frame_tick_d;
      fc_q         <= fc_d;
      troca_q      <= troca_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign h_counter   = h_q;
  assign v_counter   = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign vga_blank_n = active_q;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = vga_clk_q;
  assign pix_en      = pix_en_q;
  assign frame_tick  = frame_tick_q;
  assign troca       = troca_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Directed self-checking bench for vga_timing_gen. Three
//                instances: default geometry, a shrunken geometry with
//                TROCA_FRAMES=3 for whole-frame behaviour, and CLK_DIV=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_def = 1'b1;
  logic rst_sm  = 1'b1;
  logic rst_d4  = 1'b1;

  logic [9:0] def_h, def_v, sm_h, sm_v, d4_h, d4_v;
  logic def_hs, def_vs, def_act, def_bn, def_sn, def_vclk, def_pix, def_ft, def_tr;
  logic sm_hs, sm_vs, sm_act, sm_bn, sm_sn, sm_vclk, sm_pix, sm_ft, sm_tr;
  logic d4_hs, d4_vs, d4_act, d4_bn, d4_sn, d4_vclk, d4_pix, d4_ft, d4_tr;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen u_def (
    .clk(clk), .reset(rst_def), .h_counter(def_h), .v_counter(def_v),
    .hsync(def_hs), .vsync(def_vs), .active(def_act), .vga_blank_n(def_bn),
    .vga_sync_n(def_sn), .vga_clk(def_vclk), .pix_en(def_pix),
    .frame_tick(def_ft), .troca(def_tr)
  );

  // Small geometry: H 8+2+3+3=16 (hsync low 10..12), V 6+1+2+1=10 (vsync low 7..8)
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(2), .TROCA_FRAMES(3)
  ) u_small (
    .clk(clk), .reset(rst_sm), .h_counter(sm_h), .v_counter(sm_v),
    .hsync(sm_hs), .vsync(sm_vs), .active(sm_act), .vga_blank_n(sm_bn),
    .vga_sync_n(sm_sn), .vga_clk(sm_vclk), .pix_en(sm_pix),
    .frame_tick(sm_ft), .troca(sm_tr)
  );

  vga_timing_gen #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .reset(rst_d4), .h_counter(d4_h), .v_counter(d4_v),
    .hsync(d4_hs), .vsync(d4_vs), .active(d4_act), .vga_blank_n(d4_bn),
    .vga_sync_n(d4_sn), .vga_clk(d4_vclk), .pix_en(d4_pix),
    .frame_tick(d4_ft), .troca(d4_tr)
  );

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance the default instance by one pixel (bounded wait on pix_en).
  task automatic step_pix_def(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (def_pix !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    if (def_pix !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL pix_en_timeout: pix_en=%b after %0d cycles, required 1", def_pix, n);
      ok = 1'b0;
    end else begin
      tick();
    end
  endtask

  task automatic test_reset();
    logic       exp_pix [4];
    logic       exp_vclk[4];
    logic       exp_act [4];
    int         exp_h   [4];
    exp_pix  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_vclk = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_act  = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_h    = '{0, 1, 1, 2};
    rst_def = 1'b1;
    tick();
    tick();
    n_checks++;
    if (def_h !== 10'd0 || def_v !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_counters: h=%0d v=%0d, required 0 0", def_h, def_v);
    end
    n_checks++;
    if (def_hs !== 1'b1 || def_vs !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_sync: hsync=%b vsync=%b, required 1 1", def_hs, def_vs);
    end
    n_checks++;
    if ({def_act, def_bn, def_pix, def_vclk, def_ft, def_tr, def_sn} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: act=%b blank_n=%b pix=%b vclk=%b ft=%b troca=%b sync_n=%b, required all 0",
               def_act, def_bn, def_pix, def_vclk, def_ft, def_tr, def_sn);
    end
    rst_def = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (def_pix !== exp_pix[i] || def_vclk !== exp_vclk[i]) begin
        n_fail++;
        $display("FAIL release_div[%0d]: pix_en=%b vga_clk=%b, required %b %b",
                 i, def_pix, def_vclk, exp_pix[i], exp_vclk[i]);
      end
      n_checks++;
      if (def_h !== 10'(exp_h[i]) || def_v !== 10'd0 || def_act !== exp_act[i]) begin
        n_fail++;
        $display("FAIL release_cnt[%0d]: h=%0d v=%0d active=%b, required %0d 0 %b",
                 i, def_h, def_v, def_act, exp_h[i], exp_act[i]);
      end
    end
  endtask

  task automatic test_line();
    bit ok;
    int h, prev_h, low_cnt, first_low, first_high, inact_cnt;
    bit wrapped;
    prev_h = int'(def_h);
    low_cnt = 0; first_low = -1; first_high = -1; inact_cnt = 0; wrapped = 1'b0;
    for (int i = 0; i < 900; i++) begin
      step_pix_def(ok);
      if (!ok) break;
      h = int'(def_h);
      if (h == 0) begin
        wrapped = 1'b1;
        break;
      end
      if (def_hs === 1'b0) begin
        if (first_low < 0) first_low = h;
        low_cnt++;
      end else if (first_low >= 0 && first_high < 0) begin
        first_high = h;
      end
      if (def_act !== 1'b1) inact_cnt++;
      prev_h = h;
    end
    n_checks++;
    if (!wrapped) begin
      n_fail++;
      $display("FAIL line_wrap_seen: no wrap within bound, h=%0d, required wrap to 0", def_h);
    end
    n_checks++;
    if (first_low !== 656) begin
      n_fail++;
      $display("FAIL hsync_first_low: h=%0d, required 656", first_low);
    end
    n_checks++;
    if (first_high !== 752) begin
      n_fail++;
      $display("FAIL hsync_first_high: h=%0d, required 752", first_high);
    end
    n_checks++;
    if (low_cnt !== 96) begin
      n_fail++;
      $display("FAIL hsync_width: %0d pixels, required 96", low_cnt);
    end
    n_checks++;
    if (inact_cnt !== 160) begin
      n_fail++;
      $display("FAIL active_low_count: %0d pixels, required 160", inact_cnt);
    end
    n_checks++;
    if (prev_h !== 799 || def_v !== 10'd1 || def_act !== 1'b1 || def_hs !== 1'b1) begin
      n_fail++;
      $display("FAIL line_wrap: last_h=%0d v=%0d active=%b hsync=%b, required 799 1 1 1",
               prev_h, def_v, def_act, def_hs);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 800; i++) begin
      step_pix_def(ok);
      if (!ok) break;
      if (def_h == 10'd700) begin
        reached = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!reached || def_hs !== 1'b0 || def_v !== 10'd1) begin
      n_fail++;
      $display("FAIL mid_sync_reach: h=%0d v=%0d hsync=%b, required 700 1 0", def_h, def_v, def_hs);
    end
    #2;
    rst_def = 1'b1;
    #1;
    n_checks++;
    if (def_h !== 10'd0 || def_v !== 10'd0 || def_hs !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: h=%0d v=%0d hsync=%b, required 0 0 1", def_h, def_v, def_hs);
    end
    n_checks++;
    if (def_pix !== 1'b0 || def_vclk !== 1'b0 || def_act !== 1'b0 || def_ft !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_flags: pix=%b vclk=%b active=%b ft=%b, required 0 0 0 0",
               def_pix, def_vclk, def_act, def_ft);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (def_ft !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_tick[%0d]: frame_tick=%b, required 0", i, def_ft);
      end
    end
  endtask

  task automatic test_frame_small();
    int ticks, last_tick, vs_low_f1;
    logic prev_ft, prev_tr;
    int h, v;
    ticks = 0; last_tick = 0; vs_low_f1 = 0;
    prev_ft = 1'b0; prev_tr = 1'b0;
    rst_sm = 1'b0;
    for (int cyc = 1; cyc <= 3300; cyc++) begin
      tick();
      h = int'(sm_h);
      v = int'(sm_v);
      if (cyc >= 2) begin
        n_checks++;
        if (sm_act !== ((h < 8) && (v < 6))) begin
          n_fail++;
          $display("FAIL consist_active cyc %0d: active=%b at h=%0d v=%0d", cyc, sm_act, h, v);
        end
        n_checks++;
        if (sm_bn !== sm_act || sm_sn !== 1'b0) begin
          n_fail++;
          $display("FAIL consist_blank_sync cyc %0d: blank_n=%b sync_n=%b, required %b 0", cyc, sm_bn, sm_sn, sm_act);
        end
        n_checks++;
        if (sm_hs !== !((h >= 10) && (h < 13)) || sm_vs !== !((v >= 7) && (v < 9))) begin
          n_fail++;
          $display("FAIL consist_sync cyc %0d: hsync=%b vsync=%b at h=%0d v=%0d", cyc, sm_hs, sm_vs, h, v);
        end
      end
      if (cyc <= 320 && sm_vs === 1'b0) vs_low_f1++;
      if (prev_ft) begin
        n_checks++;
        if (sm_ft !== 1'b0) begin
          n_fail++;
          $display("FAIL frame_tick_width cyc %0d: frame_tick=%b, required 0", cyc, sm_ft);
        end
      end
      if (sm_ft !== 1'b1) begin
        n_checks++;
        if (sm_tr !== prev_tr) begin
          n_fail++;
          $display("FAIL troca_midframe cyc %0d: troca=%b, required %b", cyc, sm_tr, prev_tr);
        end
      end else begin
        ticks++;
        n_checks++;
        if (h != 0 || v != 0) begin
          n_fail++;
          $display("FAIL frame_tick_origin tick %0d: h=%0d v=%0d, required 0 0", ticks, h, v);
        end
        n_checks++;
        if ((cyc - last_tick) != 320) begin
          n_fail++;
          $display("FAIL frame_period tick %0d: %0d cycles, required 320", ticks, cyc - last_tick);
        end
        n_checks++;
        if (sm_tr !== 1'((ticks / 3) % 2)) begin
          n_fail++;
          $display("FAIL troca_wrap tick %0d: troca=%b, required %0d", ticks, sm_tr, (ticks / 3) % 2);
        end
        last_tick = cyc;
      end
      prev_ft = sm_ft;
      prev_tr = sm_tr;
    end
    n_checks++;
    if (ticks != 10) begin
      n_fail++;
      $display("FAIL frame_tick_count: %0d, required 10", ticks);
    end
    n_checks++;
    if (vs_low_f1 != 64) begin
      n_fail++;
      $display("FAIL vsync_width: %0d cycles low, required 64 (2 lines)", vs_low_f1);
    end
    n_checks++;
    if (sm_tr !== 1'b1) begin
      n_fail++;
      $display("FAIL troca_final: troca=%b, required 1", sm_tr);
    end
  endtask

  task automatic test_div4();
    int line1, line2;
    logic exp_pix[4];
    logic exp_vclk[4];
    exp_pix  = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_vclk = '{1'b0, 1'b0, 1'b1, 1'b1};
    line1 = -1; line2 = -1;
    rst_d4 = 1'b0;
    for (int cyc = 1; cyc <= 6500; cyc++) begin
      tick();
      if (cyc <= 16) begin
        n_checks++;
        if (d4_pix !== exp_pix[cyc % 4] || d4_vclk !== exp_vclk[cyc % 4]) begin
          n_fail++;
          $display("FAIL div4_pattern cyc %0d: pix_en=%b vga_clk=%b, required %b %b",
                   cyc, d4_pix, d4_vclk, exp_pix[cyc % 4], exp_vclk[cyc % 4]);
        end
      end
      if (cyc == 4) begin
        n_checks++;
        if (d4_h !== 10'd1) begin
          n_fail++;
          $display("FAIL div4_first_pixel: h=%0d, required 1", d4_h);
        end
      end
      if (line1 < 0 && d4_v == 10'd1) line1 = cyc;
      if (line2 < 0 && d4_v == 10'd2) line2 = cyc;
    end
    n_checks++;
    if (line1 != 3200) begin
      n_fail++;
      $display("FAIL div4_first_line: cycle %0d, required 3200", line1);
    end
    n_checks++;
    if ((line2 - line1) != 3200) begin
      n_fail++;
      $display("FAIL div4_line_period: %0d cycles, required 3200", line2 - line1);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_mid_reset();
    test_frame_small();
    test_div4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster timing that feeds the sprite and screen renderers: registered h_counter/v_counter, hsync/vsync, an active-video flag, a frame tick and the animation toggle `troca`.
- Targets 640x480@60 Hz from the 50 MHz board clock via an internal pixel-enable divider.
- Sits between the top level and the VGA DAC.
- All renderers sample h_counter, v_counter and troca from this block.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (must be >= 2)
- TROCA_FRAMES, 30, frames between troca toggles (must be >= 1)

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous reset, active-high
- h_counter  out  10  pixel column, 0..H_TOTAL-1
- v_counter  out  10  line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- active  out  1  high inside the visible area
- vga_blank_n  out  1  equals active
- vga_sync_n  out  1  constant 0 (no sync-on-green)
- vga_clk  out  1  pixel clock to the DAC
- pix_en  out  1  one-clk strobe per pixel
- frame_tick  out  1  one-clk pulse at frame wrap
- troca  out  1  animation phase toggle

Behaviour:
- Derived totals: H_TOTAL = sum of the H_ parameters (800); V_TOTAL = sum of the V_ parameters (525).
- Divider
  - div counts 0..CLK_DIV-1 and wraps to 0.
  - pix_en = (div == CLK_DIV-1).
  - vga_clk = (div >= CLK_DIV/2). For CLK_DIV=2 this is a 25 MHz square wave that rises on the clk edge after pix_en drops.
- Counters (advance only on clk edges where pix_en=1)
  - h_counter increments; at H_TOTAL-1 it wraps to 0 and v_counter increments.
  - v_counter wraps from V_TOTAL-1 to 0 when h_counter also wraps.
- hsync, vsync and active are registered on the same pix_en edge as the counters, computed from the next counter values. They are therefore always consistent with the counters visible in the same cycle; there is no pipeline skew.
  - hsync = 0 iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync = 0 iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
  - active = (h < H_VISIBLE) and (v < V_VISIBLE).
- frame_tick
  - Asserted for exactly one clk cycle: the cycle after the pix_en edge on which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - In that cycle the counters read (0,0).
- troca
  - A frame counter counts frame wraps, 0..TROCA_FRAMES-1.
  - On the wrap where it reaches TROCA_FRAMES-1 it resets to 0 and troca inverts.
  - troca changes only at frame wrap, never mid-frame.
- Reset (asynchronous, active-high)
  - Outputs forced immediately: div=0, h_counter=0, v_counter=0, hsync=1, vsync=1, active=0, pix_en=0, vga_clk=0, frame_tick=0, frame counter=0, troca=0.
  - The first pix_en follows CLK_DIV-1 clk edges after reset release.
  - The first pix_en edge loads (1,0), with active=1.
  - Reset mid-frame or mid-sync pulse aborts the frame; no partial frame_tick is emitted.
- Arithmetic
  - Counters are unsigned 10-bit.
  - The default parameters never exceed 799/524, so no overflow past the wrap value.

Test Plan:
- Reset release, CLK_DIV=2: pix_en high every 2nd clk; h_counter 0→1→2 on successive pix_en edges; vga_clk toggles every clk; reset asserted mid-line returns h=0, v=0, hsync=1 within the same cycle (asynchronous).
- Full line: hsync low for exactly 96 pixels, first low at h=656, high again at h=752; active low from h=640 to 799; h wraps 799→0 and v increments by 1.
- Full frame: vsync low for exactly 2 lines (v=490, 491); frame_tick single-clk pulse when counters reach (0,0); 800*525*2 = 840000 clk cycles between consecutive frame_ticks.
- troca with TROCA_FRAMES=3: troca toggles on frame wraps 3, 6, 9 after reset; it is stable throughout every frame.
- Consistency check, every cycle over 2 frames: active == (h<640 && v<480); vga_blank_n == active; vga_sync_n == 0.
- CLK_DIV=4: pix_en once per 4 clk; vga_clk 2 clk high, 2 clk low; line period is 3200 clk.
